// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
// bus_master_port : per-master serial bus port (request, address/data shift,
//                   read split, completion). Optional: BUS_MASTER_TIMEOUT_EN.
// Revision        : 1.0 - initial release
// ============================================================================
module bus_master_port #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              M_START,
    input  logic              M_RW,
    input  logic [ADDR_W-1:0] M_ADDR,
    input  logic [DATA_W-1:0] M_WDATA,
    output logic [DATA_W-1:0] M_RDATA,
    output logic              M_DONE,
    output logic              M_ERR,
    output logic              M_BUSY,
    output logic              B_REQ,
    input  logic              B_GRANT,
    output logic              B_UTIL,
    output logic              B_RW,
    output logic              B_TX,
    output logic              B_TX_VALID,
    input  logic              B_RX,
    input  logic              B_RX_VALID,
    input  logic              B_ACK,
    input  logic              B_SPLIT
);
    localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(SH_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ADDR, S_ACK_WAIT, S_WDATA, S_SPLIT_WAIT, S_RDATA, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic              r_rw, r_err;
    logic [SH_W-1:0]   r_sh;
    logic [DATA_W-1:0] r_wdata, r_rx, r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_illegal, w_last_addr, w_last_data, w_abort, w_timeout;
    logic              w_util, w_txv, w_rx_take;

    assign w_illegal   = (M_ADDR[ADDR_W-1 -: 2] == 2'b11);
    assign w_last_addr = (r_cnt == CNT_W'(ADDR_W - 1));
    assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_rx_take   = (r_state == S_RDATA) && B_GRANT && B_RX_VALID;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            r_tmo <= '0;
        else if (w_next != r_state)
            r_tmo <= '0;
        else if (r_state == S_ACK_WAIT || r_state == S_SPLIT_WAIT)
            r_tmo <= r_tmo + TMO_W'(1);
    end

    assign w_timeout = (r_state == S_ACK_WAIT || r_state == S_SPLIT_WAIT) &&
                       (r_tmo == TMO_W'(TIMEOUT - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT != 0);
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE:       if (M_START) w_next = w_illegal ? S_DONE : S_REQ;
            S_REQ:        if (B_GRANT) w_next = S_ADDR;
            S_ADDR: begin
                if (!B_GRANT) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end else if (w_last_addr) begin
                    w_next = S_ACK_WAIT;
                end
            end
            S_ACK_WAIT: begin
                // Split wins over a same-cycle ACK; only reads may be split.
                if (w_timeout) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end else if (!r_rw && B_SPLIT) begin
                    w_next = S_SPLIT_WAIT;
                end else if (B_ACK) begin
                    w_next = r_rw ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                if (!B_GRANT) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end else if (w_last_data) begin
                    w_next = S_DONE;
                end
            end
            S_SPLIT_WAIT: begin
                if (w_timeout) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end else if (B_GRANT && !B_SPLIT) begin
                    w_next = S_RDATA;
                end
            end
            S_RDATA: begin
                if (!B_GRANT) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end else if (B_RX_VALID && w_last_data) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rw    <= 1'b0;
            r_err   <= 1'b0;
            r_sh    <= '0;
            r_wdata <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE && M_START) begin
                r_rw    <= M_RW;
                r_err   <= w_illegal;
                r_sh    <= SH_W'(M_ADDR);
                r_wdata <= M_WDATA;
            end else if (w_abort) begin
                r_err <= 1'b1;
            end

            if (r_state == S_ACK_WAIT && w_next == S_WDATA)
                r_sh <= SH_W'(r_wdata);
            else if (r_state == S_ADDR || r_state == S_WDATA)
                r_sh <= r_sh >> 1;

            // LSB arrives first, so shift in from the top.
            if (w_rx_take) begin
                r_rx <= {B_RX, r_rx[DATA_W-1:1]};
                if (w_last_data)
                    r_rdata <= {B_RX, r_rx[DATA_W-1:1]};
            end

            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_ADDR || r_state == S_WDATA || w_rx_take)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_util     = (r_state == S_ADDR) || (r_state == S_ACK_WAIT) ||
                        (r_state == S_WDATA) || (r_state == S_RDATA);
    assign w_txv      = (r_state == S_ADDR) || (r_state == S_WDATA);

    assign B_UTIL     = w_util;
    assign B_REQ      = (r_state == S_REQ) || w_util ||
                        ((r_state == S_SPLIT_WAIT) && !B_SPLIT);
    assign B_RW       = r_rw & w_util;
    assign B_TX_VALID = w_txv;
    assign B_TX       = w_txv & r_sh[0];
    assign M_BUSY     = (r_state != S_IDLE);
    assign M_DONE     = (r_state == S_DONE);
    assign M_ERR      = (r_state == S_DONE) & r_err;
    assign M_RDATA    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`default_nettype none
// tb_bus_master_port : table-driven bench with a scoreboard queue; the bench
// plays arbiter and slave and compares completion, read data and bitstream.
module tb_bus_master_port;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 64;

    logic              CLK = 1'b0;
    logic              RSTN = 1'b0;
    logic              M_START = 1'b0, M_RW = 1'b0;
    logic [ADDR_W-1:0] M_ADDR = '0;
    logic [DATA_W-1:0] M_WDATA = '0;
    logic [DATA_W-1:0] M_RDATA;
    logic              M_DONE, M_ERR, M_BUSY;
    logic              B_REQ, B_UTIL, B_RW, B_TX, B_TX_VALID;
    logic              B_GRANT = 1'b0, B_RX = 1'b0, B_RX_VALID = 1'b0;
    logic              B_ACK = 1'b0, B_SPLIT = 1'b0;

    always #5 CLK = ~CLK;

    bus_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RSTN(RSTN), .M_START(M_START), .M_RW(M_RW), .M_ADDR(M_ADDR),
        .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_DONE(M_DONE), .M_ERR(M_ERR),
        .M_BUSY(M_BUSY), .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_UTIL(B_UTIL),
        .B_RW(B_RW), .B_TX(B_TX), .B_TX_VALID(B_TX_VALID), .B_RX(B_RX),
        .B_RX_VALID(B_RX_VALID), .B_ACK(B_ACK), .B_SPLIT(B_SPLIT)
    );

    logic [15:0] outs;
    assign outs = {M_RDATA, M_DONE, M_ERR, M_BUSY, B_REQ, B_UTIL, B_RW, B_TX, B_TX_VALID};

    typedef struct {
        logic        rw;
        logic [13:0] addr;
        logic [7:0]  wd;
        logic [7:0]  sd;       // data the slave returns on a read
        int          gap_at;   // bit index before which a 2-cycle RX gap occurs
        int          split_n;  // cycles of B_SPLIT in ACK_WAIT
        int          gl;       // drop grant once this many TX bits seen
        int          exp_lat;  // expected M_START->M_DONE cycles, 0 = unchecked
    } vec_t;

    typedef struct {
        logic        err;
        logic [7:0]  rdata;
        logic [21:0] bits;
        int          nbits;
        int          lat;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic run_txn(input vec_t v, input int abort_at, input bit noack);
        exp_t        e;
        logic [21:0] full, bits_act;
        int          nb, lat, phase, sc, bi, gap_left;
        bit          req_seen, done, aborted, ill;

        ill      = (v.addr[13:12] == 2'b11);
        full     = {v.wd, v.addr};
        e.err    = ill || (v.gl >= 0) || noack;
        e.nbits  = ill ? 0 : ((v.gl >= 0) ? v.gl : (v.rw ? 22 : 14));
        e.bits   = '0;
        for (int i = 0; i < e.nbits; i++) e.bits[i] = full[i];
        if (!e.err && !v.rw) model_rdata = v.sd;
        e.rdata  = model_rdata;
        e.lat    = v.exp_lat;
        sbq.push_back(e);

        @(negedge CLK);
        M_START = 1'b1; M_RW = v.rw; M_ADDR = v.addr; M_WDATA = v.wd;
        @(negedge CLK);
        M_START = 1'b0;
        lat = 1; nb = 0; bits_act = '0; phase = 0; sc = 0; bi = 0; gap_left = 2;
        req_seen = 0; done = 0; aborted = 0;

        while (!done && lat < 400) begin
            if (M_DONE) begin
                e = sbq.pop_front();
                check("done_err", 32'(M_ERR), 32'(e.err));
                check("done_rdata", 32'(M_RDATA), 32'(e.rdata));
                check("tx_nbits", 32'(nb), 32'(e.nbits));
                check("tx_bits", 32'(bits_act), 32'(e.bits));
                check("done_bus_idle", 32'({B_REQ, B_UTIL, M_BUSY}), 32'(3'b001));
                if (e.lat > 0) check("latency", 32'(lat), 32'(e.lat));
                done = 1;
            end else begin
                if (B_TX_VALID) begin
                    if (nb < 22) bits_act[nb] = B_TX;
                    nb++;
                end
                if (abort_at >= 0 && nb == abort_at) begin
                    RSTN = 1'b0;
                    #1;
                    check("async_reset_outputs", 32'(outs), 32'(0));
                    e = sbq.pop_front();
                    model_rdata = 8'h00;
                    aborted = 1;
                    done = 1;
                end else begin
                    // A stray command mid-transfer must not disturb anything.
                    if (lat == 5) begin M_START = 1'b1; M_ADDR = ~v.addr; M_RW = ~v.rw; end
                    if (lat == 6) M_START = 1'b0;
                    if (v.gl >= 0 && nb == v.gl) B_GRANT = 1'b0;
                    case (phase)
                        0: if (B_REQ) begin
                               if (req_seen) begin B_GRANT = 1'b1; phase = 1; end
                               else req_seen = 1;
                           end
                        1: if (B_UTIL && !B_TX_VALID && nb == ADDR_W && !noack) begin
                               if (v.split_n > 0) begin
                                   B_SPLIT = 1'b1; B_GRANT = 1'b0; phase = 3;
                               end else begin
                                   B_ACK = 1'b1; phase = v.rw ? 5 : 4;
                               end
                           end
                        3: begin
                               sc++;
                               check("split_util", 32'(B_UTIL), 32'(0));
                               check("split_req", 32'(B_REQ), 32'(0));
                               if (sc == v.split_n) begin B_SPLIT = 1'b0; phase = 6; end
                           end
                        6: begin
                               check("split_rereq", 32'(B_REQ), 32'(1));
                               check("split_rereq_util", 32'(B_UTIL), 32'(0));
                               B_GRANT = 1'b1; phase = 4;
                           end
                        4: begin
                               B_ACK = 1'b0;
                               if (bi < 8) begin
                                   if (bi == v.gap_at && gap_left > 0) begin
                                       B_RX_VALID = 1'b0; gap_left--;
                                   end else begin
                                       B_RX_VALID = 1'b1; B_RX = v.sd[bi]; bi++;
                                   end
                               end else begin
                                   B_RX_VALID = 1'b0;
                               end
                           end
                        default: B_ACK = 1'b0;
                    endcase
                end
            end
            if (!done) begin
                @(negedge CLK);
                lat++;
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: actual no M_DONE required M_DONE within 400 cycles");
            sbq.delete();
        end
        B_GRANT = 1'b0; B_ACK = 1'b0; B_SPLIT = 1'b0; B_RX_VALID = 1'b0; B_RX = 1'b0;
        M_START = 1'b0;
        if (aborted) begin
            @(negedge CLK);
            RSTN = 1'b1;
        end
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        tbl[0] = '{1'b1, 14'h1A5C, 8'hA5, 8'h00, -1,  0, -1, 26};
        tbl[1] = '{1'b0, 14'h0010, 8'h00, 8'h3C,  3,  0, -1,  0};
        tbl[2] = '{1'b0, 14'h1040, 8'h00, 8'hF0, -1, 10, -1,  0};
        tbl[3] = '{1'b1, 14'h3000, 8'hA5, 8'h00, -1,  0, -1,  1};
        tbl[4] = '{1'b1, 14'h2FFF, 8'h5A, 8'h00, -1,  0, -1, 26};
        tbl[5] = '{1'b0, 14'h2234, 8'h00, 8'h81, -1,  0, -1, 26};
        tbl[6] = '{1'b0, 14'h3FFF, 8'h00, 8'h99, -1,  0, -1,  1};
        tbl[7] = '{1'b1, 14'h0555, 8'h5A, 8'h00, -1,  0,  5,  8};

        repeat (3) @(negedge CLK);
        check("reset_outputs", 32'(outs), 32'(0));
        RSTN = 1'b1;
        @(negedge CLK);
        check("idle_outputs", 32'(outs), 32'(0));

        for (int i = 0; i < 8; i++) run_txn(tbl[i], -1, 1'b0);

        // Reset during data bit 3 of a write, then a clean write afterwards.
        v = '{1'b1, 14'h0ABC, 8'hC3, 8'h00, -1, 0, -1, 0};
        run_txn(v, ADDR_W + 4, 1'b0);
        v = '{1'b1, 14'h0001, 8'h7E, 8'h00, -1, 0, -1, 26};
        run_txn(v, -1, 1'b0);

`ifdef BUS_MASTER_TIMEOUT_EN
        v = '{1'b0, 14'h0100, 8'h00, 8'h00, -1, 0, -1, 17 + TIMEOUT};
        run_txn(v, -1, 1'b1);
        @(negedge CLK);
        check("timeout_release", 32'(B_UTIL), 32'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
